// File: rtl/rgb_mixer_pkg.sv
// rtl/rgb_mixer_pkg.sv - shared state codes and channel indices for the RGB channel controller
//
// Purpose: state encoding of the select sequencer (LOCKED->R->G->B->LOCKED),
//          the index of each colour channel in the level array, and the
//          select-advance helper. Imported by the RTL and by the testbench.
// Ports:   none (package).
package rgb_mixer_pkg;

  typedef enum logic [1:0] {
    ST_LOCKED = 2'd0,
    ST_R      = 2'd1,
    ST_G      = 2'd2,
    ST_B      = 2'd3
  } state_e;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;
  localparam int NUM_CH = 3;

  // One select press moves to the next state in the ring.
  function automatic state_e next_state(input state_e s);
    case (s)
      ST_LOCKED: next_state = ST_R;
      ST_R:      next_state = ST_G;
      ST_G:      next_state = ST_B;
      default:   next_state = ST_LOCKED;
    endcase
  endfunction

endpackage

// File: rtl/rgb_channel_ctrl_pwm_compare.sv
// rtl/rgb_channel_ctrl_pwm_compare.sv - registered PWM comparator for one colour channel
//
// Purpose: pwm is high for the cycle after the shared counter value is below
//          the channel level, giving a duty of level/2^WIDTH.
// Ports:   clk    in  1      rising-edge clock
//          reset  in  1      asynchronous, active-high
//          cnt    in  WIDTH  shared free-running PWM counter
//          level  in  WIDTH  channel level
//          pwm    out 1      registered PWM output
module pwm_compare #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt,
  input  logic [WIDTH-1:0] level,
  output logic             pwm
);

  logic pwm_q;
  logic pwm_d;

  always_comb begin
    pwm_d = (cnt < level);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/rgb_channel_ctrl.sv
// rtl/rgb_channel_ctrl.sv - select/encoder sequencer holding three colour levels with optional PWM
//
// Purpose: one debounced select button steps LOCKED->R->G->B->LOCKED; encoder
//          pulses saturate-adjust the level of the channel under edit. An idle
//          timeout in an edit state falls back to LOCKED, keeping the levels.
//          Build option RGB_CTRL_PWM_EN adds a shared free-running counter and
//          three registered comparators; without it pwm_* are tied low.
// Ports:   clk       in  1      rising-edge clock
//          reset     in  1      asynchronous, active-high
//          sel       in  1      debounced select level
//          enc_up    in  1      one-cycle clockwise step pulse
//          enc_down  in  1      one-cycle counter-clockwise step pulse
//          level_r/g/b out WIDTH channel levels
//          channel   out 2      0=LOCKED, 1=R, 2=G, 3=B
//          pwm_r/g/b out 1      PWM outputs
module rgb_channel_ctrl
  import rgb_mixer_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int STEP           = 1,
  parameter int RESET_LEVEL    = 0,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic             enc_up,
  input  logic             enc_down,
  output logic [WIDTH-1:0] level_r,
  output logic [WIDTH-1:0] level_g,
  output logic [WIDTH-1:0] level_b,
  output logic [1:0]       channel,
  output logic             pwm_r,
  output logic             pwm_g,
  output logic             pwm_b
);

  // Counter only needs to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WIDTH:0]   MAX_EXT   = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0]   STEP_EXT  = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] STEP_W    = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RST_LVL   = WIDTH'(RESET_LEVEL);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic [WIDTH-1:0] level_q [NUM_CH];
  logic [WIDTH-1:0] level_d [NUM_CH];

  logic sel_rise;
  logic enc_move;
  logic activity;
  logic editing;
  logic timeout;

  // Saturating step; compared in WIDTH+1 bits so MAX-STEP cannot underflow.
  function automatic logic [WIDTH-1:0] adjust(input logic [WIDTH-1:0] cur, input logic up);
    logic [WIDTH:0] cur_ext;
    cur_ext = {1'b0, cur};
    if (up) begin
      adjust = (cur_ext > (MAX_EXT - STEP_EXT)) ? {WIDTH{1'b1}} : cur + STEP_W;
    end else begin
      adjust = (cur_ext < STEP_EXT) ? '0 : cur - STEP_W;
    end
  endfunction

  always_comb begin
    sel_d    = sel;
    sel_rise = sel & ~sel_q;
    // Opposing pulses cancel in the level but still count as user activity.
    enc_move = enc_up ^ enc_down;
    activity = sel_rise | enc_up | enc_down;
    editing  = (state_q != ST_LOCKED);
    timeout  = editing && !activity && (idle_q == IDLE_LAST);
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOCKED;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (sel_rise) begin
      state_d = next_state(state_q);
    end else if (timeout) begin
      state_d = ST_LOCKED;
    end
  end

  // FSM: outputs
  always_comb begin
    channel = state_q;
  end

  // Idle counter is pinned to 0 while LOCKED and restarts on any activity.
  always_comb begin
    idle_d = idle_q + CNT_W'(1);
    if (!editing || activity || timeout) begin
      idle_d = '0;
    end
  end

  // The encoder acts on the channel selected before this edge, even when a
  // select rise moves the state on at the same edge.
  always_comb begin
    level_d = level_q;
    if (enc_move) begin
      case (state_q)
        ST_R:    level_d[CH_R] = adjust(level_q[CH_R], enc_up);
        ST_G:    level_d[CH_G] = adjust(level_q[CH_G], enc_up);
        ST_B:    level_d[CH_B] = adjust(level_q[CH_B], enc_up);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q <= 1'b0;
      idle_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        level_q[i] <= RST_LVL;
      end
    end else begin
      sel_q <= sel_d;
      idle_q <= idle_d;
      for (int i = 0; i < NUM_CH; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign level_r = level_q[CH_R];
  assign level_g = level_q[CH_G];
  assign level_b = level_q[CH_B];

`ifdef RGB_CTRL_PWM_EN
  logic [WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;

  // Natural wrap at 2^WIDTH-1 -> 0 gives a 2^WIDTH-cycle period.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  pwm_compare #(.WIDTH(WIDTH)) u_pwm_r (
    .clk(clk), .reset(reset), .cnt(pwm_cnt_q), .level(level_q[CH_R]), .pwm(pwm_r)
  );
  pwm_compare #(.WIDTH(WIDTH)) u_pwm_g (
    .clk(clk), .reset(reset), .cnt(pwm_cnt_q), .level(level_q[CH_G]), .pwm(pwm_g)
  );
  pwm_compare #(.WIDTH(WIDTH)) u_pwm_b (
    .clk(clk), .reset(reset), .cnt(pwm_cnt_q), .level(level_q[CH_B]), .pwm(pwm_b)
  );
`else
  assign pwm_r = 1'b0;
  assign pwm_g = 1'b0;
  assign pwm_b = 1'b0;
`endif

endmodule

// File: tb/tb_rgb_channel_ctrl.sv
// tb/tb_rgb_channel_ctrl.sv - self-checking bench for rgb_channel_ctrl
module tb_rgb_channel_ctrl;
  import rgb_mixer_pkg::*;

  localparam int W    = 8;
  localparam int STEP = 1;
  localparam int T    = 16;
  localparam int MAX  = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         sel = 1'b0;
  logic         enc_up = 1'b0;
  logic         enc_down = 1'b0;
  logic [W-1:0] level_r, level_g, level_b;
  logic [1:0]   channel;
  logic         pwm_r, pwm_g, pwm_b;

  int checks = 0;
  int failures = 0;

  // Reference model: channel number, integer levels, idle count, last select.
  int m_ch;
  int m_idle;
  int m_lv[3];
  bit m_sel_prev;

  rgb_channel_ctrl #(
    .WIDTH(W), .STEP(STEP), .RESET_LEVEL(0), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .sel(sel), .enc_up(enc_up), .enc_down(enc_down),
    .level_r(level_r), .level_g(level_g), .level_b(level_b), .channel(channel),
    .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_ch = 0;
    m_idle = 0;
    m_sel_prev = 1'b0;
    for (int i = 0; i < 3; i++) m_lv[i] = 0;
  endfunction

  function automatic void model_step(bit s, bit u, bit d);
    bit rise;
    bit ev;
    rise = s && !m_sel_prev;
    m_sel_prev = s;
    ev = rise || u || d;
    if (m_ch != 0 && u != d) begin
      if (u) m_lv[m_ch-1] = (m_lv[m_ch-1] + STEP > MAX) ? MAX : m_lv[m_ch-1] + STEP;
      else   m_lv[m_ch-1] = (m_lv[m_ch-1] < STEP) ? 0 : m_lv[m_ch-1] - STEP;
    end
    if (rise) begin
      m_ch = (m_ch + 1) % 4;
      m_idle = 0;
    end else if (m_ch == 0 || ev) begin
      m_idle = 0;
    end else if (m_idle == T - 1) begin
      m_ch = 0;
      m_idle = 0;
    end else begin
      m_idle++;
    end
  endfunction

  task automatic cyc(input bit s, input bit u, input bit d);
    sel = s;
    enc_up = u;
    enc_down = d;
    @(posedge clk);
    model_step(s, u, d);
    @(negedge clk);
    enc_up = 1'b0;
    enc_down = 1'b0;
  endtask

  task automatic press();
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic ups(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic downs(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (level_r !== 8'd0 || level_g !== 8'd0 || level_b !== 8'd0) begin
      failures++; $display("FAIL reset_levels got=%0d/%0d/%0d exp=0/0/0", level_r, level_g, level_b); end
    checks++; if (channel !== 2'd0) begin
      failures++; $display("FAIL reset_channel got=%0d exp=0", channel); end
    checks++; if ({pwm_r, pwm_g, pwm_b} !== 3'b000) begin
      failures++; $display("FAIL reset_pwm got=%b exp=000", {pwm_r, pwm_g, pwm_b}); end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset_mid_edit();
    press(); ups(64);
    press(); ups(64);
    press(); ups(64);
    press(); press(); press();
    checks++; if (channel !== 2'd2 || level_g !== 8'h40) begin
      failures++; $display("FAIL pre_reset_state got=ch%0d g%0d exp=ch2 g64", channel, level_g); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (level_r !== 8'd0 || level_g !== 8'd0 || level_b !== 8'd0 || channel !== 2'd0) begin
      failures++; $display("FAIL mid_edit_reset got=%0d/%0d/%0d ch%0d exp=0/0/0 ch0",
                           level_r, level_g, level_b, channel); end
    checks++; if ({pwm_r, pwm_g, pwm_b} !== 3'b000) begin
      failures++; $display("FAIL mid_edit_reset_pwm got=%b exp=000", {pwm_r, pwm_g, pwm_b}); end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_edit();
    press();
    checks++; if (channel !== 2'd1) begin
      failures++; $display("FAIL edit_enter_r got=%0d exp=1", channel); end
    ups(3);
    checks++; if (level_r !== 8'd3 || level_g !== 8'd0 || level_b !== 8'd0) begin
      failures++; $display("FAIL edit_r_up3 got=%0d/%0d/%0d exp=3/0/0", level_r, level_g, level_b); end
    press(); press(); press();
    checks++; if (channel !== 2'd0) begin
      failures++; $display("FAIL edit_back_locked got=%0d exp=0", channel); end
    ups(3);
    checks++; if (level_r !== 8'd3 || level_g !== 8'd0 || level_b !== 8'd0) begin
      failures++; $display("FAIL locked_ignores_enc got=%0d/%0d/%0d exp=3/0/0", level_r, level_g, level_b); end
  endtask

  task automatic test_saturation();
    press(); press();
    ups(254);
    checks++; if (level_g !== 8'd254) begin
      failures++; $display("FAIL sat_g_254 got=%0d exp=254", level_g); end
    ups(3);
    checks++; if (level_g !== 8'd255) begin
      failures++; $display("FAIL sat_g_max got=%0d exp=255", level_g); end
    press();
    ups(1);
    checks++; if (level_b !== 8'd1) begin
      failures++; $display("FAIL sat_b_1 got=%0d exp=1", level_b); end
    downs(2);
    checks++; if (level_b !== 8'd0 || level_r !== 8'd3) begin
      failures++; $display("FAIL sat_b_zero got=b%0d r%0d exp=b0 r3", level_b, level_r); end
  endtask

  task automatic test_simultaneous();
    press(); press();
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if (level_r !== 8'd3 || channel !== 2'd1) begin
      failures++; $display("FAIL up_down_cancel got=r%0d ch%0d exp=r3 ch1", level_r, channel); end
    cyc(1'b1, 1'b1, 1'b0);
    checks++; if (level_r !== 8'd4 || channel !== 2'd2 || level_g !== 8'd255) begin
      failures++; $display("FAIL sel_with_up got=r%0d g%0d ch%0d exp=r4 g255 ch2", level_r, level_g, channel); end
    cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 4 && m_ch != 0; i++) press();
    cyc(1'b1, 1'b0, 1'b0);
    checks++; if (channel !== 2'd1) begin
      failures++; $display("FAIL to_enter_r got=%0d exp=1", channel); end
    repeat (15) cyc(1'b0, 1'b0, 1'b0);
    checks++; if (channel !== 2'd1) begin
      failures++; $display("FAIL to_idle15 got=%0d exp=1", channel); end
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (channel !== 2'd0 || level_r !== 8'd4) begin
      failures++; $display("FAIL to_idle16 got=ch%0d r%0d exp=ch0 r4", channel, level_r); end
    cyc(1'b1, 1'b0, 1'b0);
    repeat (9) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    repeat (15) cyc(1'b0, 1'b0, 1'b0);
    checks++; if (channel !== 2'd1 || level_r !== 8'd5) begin
      failures++; $display("FAIL to_restart got=ch%0d r%0d exp=ch1 r5", channel, level_r); end
    cyc(1'b0, 1'b0, 1'b0);
    checks++; if (channel !== 2'd0) begin
      failures++; $display("FAIL to_restart_expire got=%0d exp=0", channel); end
  endtask

  task automatic test_random();
    int idle_left;
    bit s, u, d;
    idle_left = 0;
    s = sel;
    for (int n = 0; n < 600; n++) begin
      if (idle_left > 0) begin
        idle_left--;
        u = 1'b0;
        d = 1'b0;
      end else begin
        if ($urandom_range(0, 39) == 0) idle_left = $urandom_range(12, 20);
        if ($urandom_range(0, 3) == 0) s = ~s;
        u = ($urandom_range(0, 2) == 0);
        d = ($urandom_range(0, 3) == 0);
      end
      cyc(s, u, d);
      checks++; if (channel !== 2'(m_ch)) begin
        failures++; $display("FAIL rand_channel n=%0d got=%0d exp=%0d", n, channel, m_ch); end
      checks++; if (level_r !== W'(m_lv[0]) || level_g !== W'(m_lv[1]) || level_b !== W'(m_lv[2])) begin
        failures++; $display("FAIL rand_levels n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                             n, level_r, level_g, level_b, m_lv[0], m_lv[1], m_lv[2]); end
    end
  endtask

  task automatic test_pwm();
    int cnt_r, cnt_g, cnt_b;
    int exp_r;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    sel = 1'b0;
    press();
    ups(64);
    cyc(1'b0, 1'b0, 1'b0);
    cnt_r = 0; cnt_g = 0; cnt_b = 0;
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      cnt_r += int'(pwm_r);
      cnt_g += int'(pwm_g);
      cnt_b += int'(pwm_b);
    end
`ifdef RGB_CTRL_PWM_EN
    exp_r = 64;
`else
    exp_r = 0;
`endif
    checks++; if (level_r !== 8'd64) begin
      failures++; $display("FAIL pwm_level_r got=%0d exp=64", level_r); end
    checks++; if (cnt_r != exp_r) begin
      failures++; $display("FAIL pwm_r_duty got=%0d exp=%0d", cnt_r, exp_r); end
    checks++; if (cnt_g != 0 || cnt_b != 0) begin
      failures++; $display("FAIL pwm_zero_level got=%0d/%0d exp=0/0", cnt_g, cnt_b); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_reset_mid_edit();
    test_edit();
    test_saturation();
    test_simultaneous();
    test_timeout();
    test_random();
    test_pwm();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
